// File: rtl/fp_round_pipe.sv
// Two-stage pipelined IEEE-754 rounder with valid/ready handshake.
// Stage 1 normalises (right shifts only) and handles tininess, stage 2
// rounds, detects overflow, packs the result and raises exception flags.
// A sticky flag register accumulates the flags of every transferred result.
module fp_round_pipe #(
    parameter int EW = 11,
    parameter int FW = 52
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s,
    input  logic [EW+1:0]    er,
    input  logic [FW+4:0]    fr,
    input  logic [1:0]       RM,
    input  logic             OVFen,
    input  logic             UNFen,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EW+FW:0]   fp,
    output logic [2:0]       flags,
    input  logic             flags_clr,
    output logic [2:0]       flags_acc
);

    // Normalised significand: {hidden, FW fraction bits, G, R, S}.
    localparam int SW  = FW + 4;
    // Internal exponent is wider than er so er+1 and the wrap adjustments never overflow.
    localparam int XW  = EW + 3;
    localparam int SHW = $clog2(SW);

    localparam logic signed [XW-1:0] ONE    = XW'(1);
    localparam logic signed [XW-1:0] WRAP   = XW'(3 * (2 ** (EW - 2)));
    localparam logic signed [XW-1:0] EMAX   = XW'((2 ** EW) - 1);
    localparam logic        [XW-1:0] SH_CAP = XW'(FW + 3);

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RZ  = 2'b01,
        RM_RU  = 2'b10,
        RM_RD  = 2'b11
    } rm_e;

    // Handshake state
    logic v1_q, v2_q;
    logic en1, en2;

    // Stage 1 combinational signals
    logic signed [XW-1:0] er_x;
    logic signed [XW-1:0] norm_e;
    logic        [SW-1:0] norm_sig;
    logic        [XW-1:0] sh_raw;
    logic       [SHW-1:0] sh;
    logic        [SW-1:0] sh_mask;
    logic                 in_zero, in_tiny;
    logic        [SW-1:0] sig1_d;
    logic signed [XW-1:0] e1_d;
    logic                 den1_d;

    // Stage 1 registers
    logic                 s1_q;
    logic        [SW-1:0] sig1_q;
    logic signed [XW-1:0] e1_q;
    logic                 tiny1_q, den1_q, zero1_q;
    rm_e                  rm1_q;
    logic                 ovfen1_q, unfen1_q;

    // Stage 2 combinational signals
    logic                 rbits, inc, carry, ovf, inx, unf, to_inf;
    logic        [FW+1:0] mant;
    logic        [FW-1:0] frac;
    logic signed [XW-1:0] e_rnd;
    logic       [EW+FW:0] fp2_d;
    logic           [2:0] flags2_d;

    // Stage 2 / output registers
    logic       [EW+FW:0] fp_q;
    logic           [2:0] flags_q;
    logic           [2:0] flags_acc_q;
    logic                 xfer;

    assign en2       = ~v2_q | out_ready;
    assign en1       = ~v1_q | en2;
    assign in_ready  = en1;
    assign out_valid = v2_q;
    assign xfer      = v2_q & out_ready;

    // Outputs read zero whenever no result is presented.
    assign fp        = v2_q ? fp_q    : '0;
    assign flags     = v2_q ? flags_q : '0;
    assign flags_acc = flags_acc_q;

    // Stage 1: normalise the carry bit away and resolve tininess.
    always_comb begin
        // NOTE: every variable gets a value on every path before any
        // conditional override, so no latch can be inferred.
        in_zero = (fr == '0);
        er_x    = {er[EW+1], er};
        if (fr[FW+4]) begin
            norm_sig = {fr[FW+4:2], fr[1] | fr[0]};
            norm_e   = er_x + ONE;
        end else begin
            norm_sig = fr[FW+3:0];
            norm_e   = er_x;
        end
        in_tiny = ~in_zero & (norm_e < ONE);
        sh_raw  = ONE - norm_e;
        sh      = (sh_raw > SH_CAP) ? SHW'(SH_CAP) : sh_raw[SHW-1:0];
        sh_mask = ~({SW{1'b1}} << sh);

        sig1_d = norm_sig;
        e1_d   = norm_e;
        den1_d = 1'b0;
        if (in_tiny) begin
            if (!UNFen) begin
                // Denormalise: everything shifted past S collapses into S.
                sig1_d = (norm_sig >> sh) | {{(SW-1){1'b0}}, |(norm_sig & sh_mask)};
                e1_d   = '0;
                den1_d = 1'b1;
            end else begin
                e1_d = norm_e + WRAP;
            end
        end
    end

    // Stage 1 datapath register, loaded only when an operand is accepted.
    always_ff @(posedge clk) begin
        // NOTE: pure datapath carries no reset; out_valid qualifies it and
        // the outputs are forced to zero while it is low.
        if (en1 && in_valid) begin
            s1_q     <= s;
            sig1_q   <= sig1_d;
            e1_q     <= e1_d;
            tiny1_q  <= in_tiny;
            den1_q   <= den1_d;
            zero1_q  <= in_zero;
            rm1_q    <= rm_e'(RM);
            ovfen1_q <= OVFen;
            unfen1_q <= UNFen;
        end
    end

    // Stage 2: round, detect overflow, pack and compute flags.
    always_comb begin
        rbits = |sig1_q[2:0];
        inc   = 1'b0;
        case (rm1_q)
            RM_RNE: inc = sig1_q[2] & (sig1_q[1] | sig1_q[0] | sig1_q[3]);
            RM_RZ:  inc = 1'b0;
            RM_RU:  inc = ~s1_q & rbits;
            RM_RD:  inc = s1_q & rbits;
        endcase

        mant  = {1'b0, sig1_q[SW-1:3]} + {{(FW+1){1'b0}}, inc};
        carry = mant[FW+1];
        frac  = carry ? mant[FW:1] : mant[FW-1:0];

        // A denormal that rounds into the hidden bit becomes the smallest normal.
        if (den1_q) e_rnd = {{(XW-1){1'b0}}, mant[FW]};
        else        e_rnd = e1_q + {{(XW-1){1'b0}}, carry};

        ovf = ~zero1_q & (e_rnd >= EMAX);
        inx = rbits | (ovf & ~ovfen1_q);
        unf = unfen1_q ? tiny1_q : (tiny1_q & inx);

        to_inf = 1'b0;
        case (rm1_q)
            RM_RNE: to_inf = 1'b1;
            RM_RZ:  to_inf = 1'b0;
            RM_RU:  to_inf = ~s1_q;
            RM_RD:  to_inf = s1_q;
        endcase

        fp2_d = {s1_q, e_rnd[EW-1:0], frac};
        if (zero1_q) begin
            fp2_d = {s1_q, {(EW+FW){1'b0}}};
        end else if (ovf && ovfen1_q) begin
            fp2_d = {s1_q, EW'(e_rnd - WRAP), frac};
        end else if (ovf) begin
            fp2_d = to_inf ? {s1_q, {EW{1'b1}}, {FW{1'b0}}}
                           : {s1_q, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};
        end
        flags2_d = zero1_q ? 3'b000 : {ovf, unf, inx};
    end

    // Stage 2 result register; holds while the downstream stalls.
    always_ff @(posedge clk) begin
        if (en2 && v1_q) begin
            fp_q    <= fp2_d;
            flags_q <= flags2_d;
        end
    end

    // Pipeline valid bits; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            if (en1) v1_q <= in_valid;
            if (en2) v2_q <= v1_q;
        end
    end

    // Sticky flags; a transferring result survives a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_acc_q <= 3'b000;
        end else begin
            flags_acc_q <= (flags_clr ? 3'b000 : flags_acc_q) | (xfer ? flags : 3'b000);
        end
    end

endmodule

// File: tb/tb_fp_round_pipe.sv
// Self-checking bench for fp_round_pipe (binary64 configuration).
// Directed cases carry hand-derived constants; random traffic is checked
// against an integer-arithmetic model through an in-order scoreboard.
module tb_fp_round_pipe;

    localparam int EW = 11;
    localparam int FW = 52;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          s;
    logic [EW+1:0] er;
    logic [FW+4:0] fr;
    logic [1:0]    rm;
    logic          ovfen;
    logic          unfen;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   fp;
    logic [2:0]    flags;
    logic          flags_clr;
    logic [2:0]    flags_acc;

    int          n_asserts = 0;
    int          n_fails   = 0;
    logic [63:0] exp_fp_q[$];
    logic [2:0]  exp_fl_q[$];
    logic [2:0]  acc_model = 3'b000;
    logic [63:0] cur_fp;
    logic [2:0]  cur_fl;
    bit          accepted;

    always #5 clk = ~clk;

    fp_round_pipe #(.EW(EW), .FW(FW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .er        (er),
        .fr        (fr),
        .RM        (rm),
        .OVFen     (ovfen),
        .UNFen     (unfen),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp        (fp),
        .flags     (flags),
        .flags_clr (flags_clr),
        .flags_acc (flags_acc)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: value-level rounding with plain integer arithmetic.
    function automatic void model(input logic sg, input logic [EW+1:0] e_in,
                                  input logic [FW+4:0] f_in, input logic [1:0] mode,
                                  input logic oen, input logic uen,
                                  output logic [63:0] r_fp, output logic [2:0] r_fl);
        logic [63:0] m, q, rem;
        int          e, sh;
        logic        tiny, den, inx, up, ovf, unf, to_inf;
        logic [31:0] eb;
        r_fp = {sg, 63'd0};
        r_fl = 3'b000;
        if (f_in == '0) return;
        m = 64'(f_in);
        e = int'($signed(e_in));
        if (m >= (64'd1 << (FW + 4))) begin
            m = (m >> 1) | 64'(m[0]);
            e = e + 1;
        end
        tiny = (e < 1);
        den  = 1'b0;
        if (tiny && !uen) begin
            sh  = (1 - e > FW + 3) ? FW + 3 : 1 - e;
            rem = m & ((64'd1 << sh) - 64'd1);
            m   = (m >> sh) | 64'(rem != 64'd0);
            e   = 0;
            den = 1'b1;
        end else if (tiny) begin
            e = e + 3 * (1 << (EW - 2));
        end
        q   = m >> 3;
        rem = m & 64'd7;
        inx = (rem != 64'd0);
        case (mode)
            2'b00:   up = (rem > 64'd4) || (rem == 64'd4 && q[0]);
            2'b01:   up = 1'b0;
            2'b10:   up = inx && !sg;
            default: up = inx && sg;
        endcase
        q = q + 64'(up);
        if (q == (64'd1 << (FW + 1))) begin
            q = q >> 1;
            e = e + 1;
        end
        if (den && q >= (64'd1 << FW)) e = 1;
        ovf = (e >= (1 << EW) - 1);
        unf = uen ? tiny : (tiny && inx);
        if (ovf && !oen) begin
            case (mode)
                2'b00:   to_inf = 1'b1;
                2'b01:   to_inf = 1'b0;
                2'b10:   to_inf = !sg;
                default: to_inf = sg;
            endcase
            r_fp = to_inf ? {sg, {EW{1'b1}}, {FW{1'b0}}} : {sg, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};
            r_fl = {1'b1, unf, 1'b1};
            return;
        end
        if (ovf) e = e - 3 * (1 << (EW - 2));
        eb   = 32'(e);
        r_fp = {sg, eb[EW-1:0], q[FW-1:0]};
        r_fl = {ovf, unf, inx};
    endfunction

    task automatic set_op(input logic sg, input logic [EW+1:0] e_in, input logic [FW+4:0] f_in,
                          input logic [1:0] mode, input logic oen, input logic uen);
        s     = sg;
        er    = e_in;
        fr    = f_in;
        rm    = mode;
        ovfen = oen;
        unfen = uen;
        model(sg, e_in, f_in, mode, oen, uen, cur_fp, cur_fl);
    endtask

    task automatic rand_op();
        int          v;
        logic [1:0]  top;
        logic [63:0] lo;
        logic [FW+4:0] f;
        case ($urandom_range(0, 3))
            0:       v = int'($urandom_range(1, 2046));
            1:       v = int'($urandom_range(2035, 2060));
            2:       v = -int'($urandom_range(0, 60));
            default: v = int'($urandom_range(0, 3)) - 1;
        endcase
        top = 2'($urandom_range(1, 3));
        lo  = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) lo[29:0] = '0;
        f = {top, lo[FW+2:0]};
        if ($urandom_range(0, 19) == 0) f = '0;
        set_op(1'($urandom_range(0, 1)), 13'(v), f, 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // One clock: observe at the falling edge, then advance past the rising edge.
    task automatic cycle();
        logic [63:0] efp;
        logic [2:0]  efl;
        @(negedge clk);
        check("flags_acc", 64'(flags_acc), 64'(acc_model));
        if (!out_valid) begin
            check("idle_fp", fp, 64'd0);
            check("idle_flags", 64'(flags), 64'd0);
        end
        accepted = in_valid && in_ready;
        efl = 3'b000;
        if (out_valid && out_ready) begin
            if (exp_fp_q.size() == 0) begin
                check("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                efp = exp_fp_q.pop_front();
                efl = exp_fl_q.pop_front();
                check("fp", fp, efp);
                check("flags", 64'(flags), 64'(efl));
            end
        end
        acc_model = (flags_clr ? 3'b000 : acc_model) | efl;
        if (accepted) begin
            exp_fp_q.push_back(cur_fp);
            exp_fl_q.push_back(cur_fl);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send();
        bit done = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle();
            done = accepted;
        end
        in_valid = 1'b0;
        check("accept_timeout", 64'(done), 64'd1);
    endtask

    task automatic dir(input logic sg, input logic [EW+1:0] e_in, input logic [FW+4:0] f_in,
                       input logic [1:0] mode, input logic oen, input logic uen,
                       input logic [63:0] efp, input logic [2:0] efl);
        set_op(sg, e_in, f_in, mode, oen, uen);
        cur_fp = efp;
        cur_fl = efl;
        send();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 60 && exp_fp_q.size() != 0; i++) cycle();
        check("drain_empty", 64'(exp_fp_q.size()), 64'd0);
    endtask

    initial begin
        int n_acc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flags_clr = 1'b0;
        set_op(1'b0, '0, '0, 2'b00, 1'b0, 1'b0);

        // Reset state
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_fp", fp, 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_flags_acc", 64'(flags_acc), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // 3.0 + 3.0 with a two-cycle latency check
        dir(1'b0, 13'd1024, {2'b11, 55'd0}, 2'b00, 1'b0, 1'b0, 64'h4018000000000000, 3'b000);
        check("lat_one_edge", 64'(out_valid), 64'd0);
        cycle();
        check("lat_two_edges", 64'(out_valid), 64'd1);
        drain();

        // Tie-to-even and truncation
        dir(1'b0, 13'd1023, {2'b01, 51'd0, 1'b1, 3'b100}, 2'b00, 1'b0, 1'b0, 64'h3FF0000000000002, 3'b001);
        dir(1'b0, 13'd1023, {2'b01, 51'd0, 1'b1, 3'b100}, 2'b01, 1'b0, 1'b0, 64'h3FF0000000000001, 3'b001);
        // Overflow, untrapped and trapped
        dir(1'b0, 13'd2047, {2'b01, 55'd0}, 2'b00, 1'b0, 1'b0, 64'h7FF0000000000000, 3'b101);
        dir(1'b0, 13'd2047, {2'b01, 55'd0}, 2'b01, 1'b0, 1'b0, 64'h7FEFFFFFFFFFFFFF, 3'b101);
        dir(1'b0, 13'd2047, {2'b01, 55'd0}, 2'b00, 1'b1, 1'b0, 64'h1FF0000000000000, 3'b100);
        dir(1'b1, 13'd2047, {2'b01, 55'd0}, 2'b10, 1'b0, 1'b0, 64'hFFEFFFFFFFFFFFFF, 3'b101);
        // Underflow to denormals, exact and inexact
        dir(1'b0, 13'h1FFF, {2'b01, 55'd0}, 2'b00, 1'b0, 1'b0, 64'h0004000000000000, 3'b000);
        dir(1'b0, 13'h1FFF, {2'b01, 54'd0, 1'b1}, 2'b10, 1'b0, 1'b0, 64'h0004000000000001, 3'b011);
        // Denormal rounding into the hidden bit, and signed zero
        dir(1'b0, 13'd0, {2'b01, {55{1'b1}}}, 2'b00, 1'b0, 1'b0, 64'h0010000000000000, 3'b011);
        dir(1'b1, 13'd77, '0, 2'b10, 1'b1, 1'b1, 64'h8000000000000000, 3'b000);
        drain();

        // Flag accumulation: INX then OVF, then clear on the cycle of an UNF transfer
        flags_clr = 1'b1;
        cycle();
        flags_clr = 1'b0;
        check("acc_cleared", 64'(flags_acc), 64'd0);
        dir(1'b0, 13'd1023, {2'b01, 51'd0, 1'b1, 3'b100}, 2'b00, 1'b0, 1'b0, 64'h3FF0000000000002, 3'b001);
        dir(1'b0, 13'd2047, {2'b01, 55'd0}, 2'b00, 1'b1, 1'b0, 64'h1FF0000000000000, 3'b100);
        drain();
        check("acc_inx_ovf", 64'(flags_acc), 64'h5);
        out_ready = 1'b0;
        dir(1'b0, 13'h1FFF, {2'b01, 55'd0}, 2'b00, 1'b0, 1'b1, 64'h5FF0000000000000, 3'b010);
        for (int i = 0; i < 10 && !out_valid; i++) cycle();
        check("unf_presented", 64'(out_valid), 64'd1);
        flags_clr = 1'b1;
        out_ready = 1'b1;
        cycle();
        flags_clr = 1'b0;
        check("acc_clr_unf", 64'(flags_acc), 64'h2);

        // Backpressure: four back-to-back operands against a stalled sink
        out_ready = 1'b0;
        n_acc     = 0;
        rand_op();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (accepted) begin
                n_acc++;
                rand_op();
            end
            if (i >= 2) check("bp_fp_held", fp, exp_fp_q[0]);
        end
        check("bp_accepts", 64'(n_acc), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && n_acc < 4; i++) begin
            cycle();
            if (accepted) begin
                n_acc++;
                rand_op();
            end
        end
        in_valid = 1'b0;
        check("bp_all_accepted", 64'(n_acc), 64'd4);
        drain();

        // Reset in the middle of a stream
        out_ready = 1'b0;
        rand_op();
        in_valid = 1'b1;
        cycle();
        rand_op();
        cycle();
        in_valid = 1'b0;
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_fp", fp, 64'd0);
        check("midrst_flags", 64'(flags), 64'd0);
        check("midrst_flags_acc", 64'(flags_acc), 64'd0);
        exp_fp_q.delete();
        exp_fl_q.delete();
        acc_model = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_out_valid", 64'(out_valid), 64'd0);

        // Random traffic with random stalls and clears
        for (int i = 0; i < 400; i++) begin
            rand_op();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flags_clr = ($urandom_range(0, 15) == 0);
            cycle();
        end
        in_valid  = 1'b0;
        flags_clr = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
